// File: rtl/arith_pkg.sv
// arith_pkg -- definitions shared by the arithmetic datapath blocks.
//
// Contents:
//   sub_state_t : control states of the bit-serial subtractor sub_serial
//   ARITH_W     : default operand width, shared by add and sub_serial
package arith_pkg;

   localparam int ARITH_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage : arith_pkg

// File: rtl/fsub.sv
// fsub -- one-bit full subtractor, the subtracting counterpart of fadd.
// Purely combinational; computes a - b - bin for single bits.
//
// Ports:
//   a    : in  1  minuend bit
//   b    : in  1  subtrahend bit
//   bin  : in  1  borrow in
//   d    : out 1  difference bit
//   bout : out 1  borrow out
module fsub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when b exceeds a outright, or when a == b and a borrow arrives.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : fsub

// File: rtl/sub_serial.sv
// sub_serial -- bit-serial subtractor computing num1 - num2, LSB first,
// through a single fsub cell. Uses WIDTH+1 cycles per result in exchange
// for a one-bit arithmetic core.
//
// Optional feature: define SUB_SERIAL_OVF_EN to add the 'ovf' output
// (signed two's-complement overflow of num1 - num2).
//
// Ports:
//   clk   : in  1      clock, rising edge
//   rst_n : in  1      asynchronous active-low reset
//   start : in  1      request a subtraction (taken only when not busy)
//   num1  : in  WIDTH  minuend, sampled when start is accepted
//   num2  : in  WIDTH  subtrahend, sampled when start is accepted
//   busy  : out 1      high while bits are being processed
//   done  : out 1      one-cycle pulse when out/bout are freshly valid
//   out   : out WIDTH  num1 - num2 mod 2^WIDTH, held until the next result
//   bout  : out 1      final borrow, 1 iff num1 < num2 unsigned
//   ovf   : out 1      (SUB_SERIAL_OVF_EN only) signed overflow
//
// Handshake: start is accepted on a rising edge where the block is in IDLE
// or DONE (busy low); the operands are captured on that same edge. busy is
// then high for exactly WIDTH cycles, and done pulses for one cycle in the
// cycle after, with out/bout (and ovf) already updated. start while busy
// is ignored. Holding start through the done cycle chains the next
// operation with no idle gap.
module sub_serial
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             bout
`ifdef SUB_SERIAL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   sub_state_t       state;
   sub_state_t       state_n;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             bi;
   logic [CW-1:0]    cnt;

   logic             d_bit;
   logic             bo_bit;
   logic             load;
   logic             step;
   logic             last;

   fsub u_fsub (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (bi),
      .d    (d_bit),
      .bout (bo_bit)
   );

   // The step processing bit WIDTH-1 is the final one.
   assign last = (cnt == CW'(WIDTH - 1));

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            // Back-to-back: a start here skips IDLE entirely.
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr <= '0;
         b_sr <= '0;
         r_sr <= '0;
         bi   <= 1'b0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         out  <= '0;
         bout <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         // Status flags follow the next state so they line up with it.
         busy <= (state_n == RUN);
         done <= (state_n == DONE);

         if (load) begin
            a_sr <= num1;
            b_sr <= num2;
            r_sr <= '0;
            bi   <= 1'b0;
            cnt  <= '0;
         end else if (step) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= {d_bit, r_sr[WIDTH-1:1]};
            bi   <= bo_bit;
            cnt  <= cnt + CW'(1);
            if (last) begin
               // Final bit lands in the MSB together with the published result.
               out  <= {d_bit, r_sr[WIDTH-1:1]};
               bout <= bo_bit;
`ifdef SUB_SERIAL_OVF_EN
               // On the last step a_sr[0]/b_sr[0] hold the operand sign bits.
               ovf  <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
`endif
            end
         end
      end
   end

endmodule : sub_serial

// File: tb/tb_sub_serial.sv
// tb_sub_serial -- self-checking bench for sub_serial (WIDTH = 4).
// A timing/arithmetic model derived from the accept-to-done latency and
// plain integer subtraction is compared against the DUT every cycle;
// directed cases pin literal results.
`timescale 1ns/1ps
module tb_sub_serial;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] num1;
   logic [W-1:0] num2;
   logic         busy;
   logic         done;
   logic [W-1:0] out;
   logic         bout;
   logic         ovf;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   sub_serial #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .num1  (num1),
      .num2  (num2),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .bout  (bout)
`ifdef SUB_SERIAL_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

`ifndef SUB_SERIAL_OVF_EN
   assign ovf = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // m_left: cycles still to go before the result appears (0 = not running).
   int           m_left;
   bit           m_done;
   logic [W-1:0] e_out;
   logic         e_bout;
   logic         e_ovf;
   logic [W-1:0] p_out;
   logic         p_bout;
   logic         p_ovf;

   function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa;
      int sb;
      int df;
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      df = sa - sb;
      return (df > (1 << (W-1)) - 1) || (df < -(1 << (W-1)));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         e_out  <= '0;
         e_bout <= 1'b0;
         e_ovf  <= 1'b0;
      end else begin
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            e_out  <= p_out;
            e_bout <= p_bout;
            e_ovf  <= p_ovf;
         end
         if (start && m_left == 0) begin
            m_left <= W;
            p_out  <= W'((int'(num1) - int'(num2)) & ((1 << W) - 1));
            p_bout <= (int'(num1) < int'(num2));
            p_ovf  <= signed_ovf(num1, num2);
         end else if (m_left > 0) begin
            m_left <= m_left - 1;
         end
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
         chk("cyc_done", {31'd0, done}, {31'd0, m_done});
         chk("cyc_out",  {28'd0, out},  {28'd0, e_out});
         chk("cyc_bout", {31'd0, bout}, {31'd0, e_bout});
`ifdef SUB_SERIAL_OVF_EN
         chk("cyc_ovf",  {31'd0, ovf},  {31'd0, e_ovf});
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from idle and pin its literal results and timing.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic eb, input logic eov,
                         input string nm);
      int busy_n;
      int lat;
      bit got;
      start = 1'b1;
      num1  = a;
      num2  = b;
      cyc();
      start  = 1'b0;
      lat    = 1;
      busy_n = 0;
      got    = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         if (busy) busy_n++;
         if (done) got = 1'b1;
         else begin
            cyc();
            lat++;
         end
      end
      chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
      chk({nm, "_latency"}, lat, W + 1);
      chk({nm, "_busy_cycles"}, busy_n, W);
      chk({nm, "_out"}, {28'd0, out}, {28'd0, eo});
      chk({nm, "_bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SUB_SERIAL_OVF_EN
      chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eov});
`else
      if (eov === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
      cyc();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int done_n;
      int gap;
      rst_n = 1'b0;
      start = 1'b0;
      num1  = '0;
      num2  = '0;
      #12;
      cmp_en = 1'b1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_out",  {28'd0, out},  32'd0);
      chk("rst_bout", {31'd0, bout}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      run_op(4'd7, 4'd3, 4'd4,  1'b0, 1'b0, "sub7_3");
      run_op(4'd3, 4'd7, 4'd12, 1'b1, 1'b0, "sub3_7");
      run_op(4'd8, 4'd1, 4'd7,  1'b0, 1'b1, "sub8_1");

      // Start during RUN must be ignored.
      start = 1'b1; num1 = 4'd15; num2 = 4'd15;
      cyc();
      start = 1'b0;
      cyc();
      start = 1'b1; num1 = 4'd9; num2 = 4'd2;
      cyc();
      start = 1'b0;
      done_n = 0;
      for (int t = 0; t < 10; t++) begin
         if (done) done_n++;
         cyc();
      end
      chk("ign_done_pulses", done_n, 1);
      chk("ign_out",  {28'd0, out},  32'd0);
      chk("ign_bout", {31'd0, bout}, 32'd0);

      // Back-to-back: start held through the done cycle.
      start = 1'b1; num1 = 4'd10; num2 = 4'd4;
      cyc();
      num1 = 4'd5; num2 = 4'd1;
      for (int t = 0; t < 10 && !done; t++) cyc();
      chk("b2b_first_done", {31'd0, done}, 32'd1);
      chk("b2b_first_out", {28'd0, out}, 32'd6);
      chk("b2b_busy_in_done", {31'd0, busy}, 32'd0);
      cyc();
      start = 1'b0;
      chk("b2b_busy_after", {31'd0, busy}, 32'd1);
      gap = 1;
      for (int t = 0; t < 10 && !done; t++) begin
         cyc();
         gap++;
      end
      chk("b2b_gap", gap, W + 1);
      chk("b2b_second_out", {28'd0, out}, 32'd4);
      cyc();
      cyc();

      // Reset in the 2nd RUN cycle aborts the operation.
      start = 1'b1; num1 = 4'd12; num2 = 4'd5;
      cyc();
      start = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_out",  {28'd0, out},  32'd0);
      chk("abort_bout", {31'd0, bout}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      done_n = 0;
      for (int t = 0; t < 8; t++) begin
         if (done) done_n++;
         cyc();
      end
      chk("abort_no_done", done_n, 0);
      run_op(4'd12, 4'd5, 4'd7, 1'b0, 1'b1, "sub12_5");

      // Randomized traffic, including starts during RUN and back-to-back.
      for (int t = 0; t < 600; t++) begin
         start = ($urandom_range(0, 2) == 0);
         num1  = W'($urandom_range(0, (1 << W) - 1));
         num2  = W'($urandom_range(0, (1 << W) - 1));
         cyc();
      end
      start = 1'b0;
      for (int t = 0; t < 2 * W + 4; t++) cyc();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sub_serial
